// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator.
// Holds the 640x480@60 default line/frame geometry, the derived totals,
// coordinate/counter widths and the idle value of the delayed sync bundle.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    // {hs_n, vs_n, blank_n} while idle: both syncs released, video blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align sync/blank with the
// downstream registered colour path.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, loads RST_VAL into every stage
//   d_i    - input word
//   q_o    - input word delayed by DEPTH clocks (combinational pass-through when DEPTH=0)
module vga_delay_line #(
    parameter int                DEPTH   = 2,
    parameter int                WIDTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator for the VGA path.
// Free-running horizontal/vertical counters on the pixel clock; presents
// active-area coordinates and line/frame markers aligned with the counters,
// and sync/blank delayed by PIX_LATENCY to match the downstream colour stage.
// Ports:
//   iVGA_CLK      - pixel clock
//   iRST          - asynchronous active-high reset
//   oVGA_X/Y      - active-area coordinates, forced to 0 outside the active area
//   oActive       - counters are inside the active area
//   oLine_Start   - h_cnt at 0
//   oFrame_Start  - h_cnt and v_cnt at 0
//   oVGA_HS/VS    - active-low syncs, delayed PIX_LATENCY clocks
//   oVGA_BLANK_n  - high during active video, delayed PIX_LATENCY clocks
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int PIX_LATENCY = 2
) (
    input  logic           iVGA_CLK,
    input  logic           iRST,
    output logic [X_W-1:0] oVGA_X,
    output logic [Y_W-1:0] oVGA_Y,
    output logic           oActive,
    output logic           oLine_Start,
    output logic           oFrame_Start,
    output logic           oVGA_HS,
    output logic           oVGA_VS,
    output logic           oVGA_BLANK_n
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap, v_wrap;
    logic             active, hs_raw_n, vs_raw_n;
    logic [2:0]       sync_raw, sync_dly;

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // v_cnt only moves on the h_cnt wrap clock, so both wrap on the same edge.
    always_comb begin
        h_wrap  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap  = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        active   = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        hs_raw_n = !((h_cnt_q >= CNT_W'(H_SYNC_START)) && (h_cnt_q < CNT_W'(H_SYNC_END)));
        vs_raw_n = !((v_cnt_q >= CNT_W'(V_SYNC_START)) && (v_cnt_q < CNT_W'(V_SYNC_END)));
    end

    // Coordinates are zeroed outside the active area so downstream
    // comparisons never see porch/sync counter values.
    assign oVGA_X       = active ? h_cnt_q[X_W-1:0] : '0;
    assign oVGA_Y       = active ? v_cnt_q[Y_W-1:0] : '0;
    assign oActive      = active;
    assign oLine_Start  = (h_cnt_q == '0);
    assign oFrame_Start = (h_cnt_q == '0) && (v_cnt_q == '0);

    assign sync_raw = {hs_raw_n, vs_raw_n, active};

    vga_delay_line #(
        .DEPTH   (PIX_LATENCY),
        .WIDTH   (3),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk_i (iVGA_CLK),
        .rst_i (iRST),
        .d_i   (sync_raw),
        .q_o   (sync_dly)
    );

    assign oVGA_HS      = sync_dly[2];
    assign oVGA_VS      = sync_dly[1];
    assign oVGA_BLANK_n = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a: default geometry, latency 2
    // s: short frame (30 lines: 20 active, 3 fp, 2 sync, 5 bp), latency 2
    // z: default geometry, latency 0
    logic [9:0] a_x, s_x, z_x;
    logic [8:0] a_y, s_y, z_y;
    logic a_act, a_ls, a_fs, a_hs, a_vs, a_bl;
    logic s_act, s_ls, s_fs, s_hs, s_vs, s_bl;
    logic z_act, z_ls, z_fs, z_hs, z_vs, z_bl;

    vga_timing_gen #(.PIX_LATENCY(2)) dut_a (
        .iVGA_CLK(clk), .iRST(rst), .oVGA_X(a_x), .oVGA_Y(a_y), .oActive(a_act),
        .oLine_Start(a_ls), .oFrame_Start(a_fs), .oVGA_HS(a_hs), .oVGA_VS(a_vs),
        .oVGA_BLANK_n(a_bl));

    vga_timing_gen #(.V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5), .PIX_LATENCY(2)) dut_s (
        .iVGA_CLK(clk), .iRST(rst), .oVGA_X(s_x), .oVGA_Y(s_y), .oActive(s_act),
        .oLine_Start(s_ls), .oFrame_Start(s_fs), .oVGA_HS(s_hs), .oVGA_VS(s_vs),
        .oVGA_BLANK_n(s_bl));

    vga_timing_gen #(.PIX_LATENCY(0)) dut_z (
        .iVGA_CLK(clk), .iRST(rst), .oVGA_X(z_x), .oVGA_Y(z_y), .oActive(z_act),
        .oLine_Start(z_ls), .oFrame_Start(z_fs), .oVGA_HS(z_hs), .oVGA_VS(z_vs),
        .oVGA_BLANK_n(z_bl));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    localparam int A_SPAN = 2000;
    localparam int S_FRAME = 24000;
    localparam int MRST_K = S_FRAME + 10*800 + 700;

    int a_lsq[$], a_hs_fall[$], a_hs_rise[$], a_bl_rise[$], a_bl_fall[$];
    int a_hs_low_l0, a_bl_high_l1, a_xmax, a_zero_viol;
    int a_x805, a_y805, a_x640, a_act640;
    logic a_hs_p, a_bl_p;

    int s_fsq[$];
    int s_vs_fall, s_vs_low, s_xmax, s_ymax, s_act_cnt, s_zero_viol;
    logic s_vs_p;

    int z_bl_viol, z_hs_fall, z_hs_rise, z_x_at_fall;
    logic z_hs_p;

    int m_hs_fall, m_hs_low;
    logic m_hs_p;

    initial begin
        a_hs_low_l0 = 0; a_bl_high_l1 = 0; a_xmax = 0; a_zero_viol = 0;
        a_x805 = -1; a_y805 = -1; a_x640 = -1; a_act640 = -1;
        s_vs_fall = -1; s_vs_low = 0; s_xmax = 0; s_ymax = 0; s_act_cnt = 0; s_zero_viol = 0;
        z_bl_viol = 0; z_hs_fall = -1; z_hs_rise = -1; z_x_at_fall = -1;
        m_hs_fall = -1; m_hs_low = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hs",    a_hs, 1);
        chk("rst_vs",    a_vs, 1);
        chk("rst_blank", a_bl, 0);
        chk("rst_x",     a_x, 0);
        chk("rst_y",     a_y, 0);
        chk("rst_fs",    a_fs, 1);
        chk("rst_ls",    a_ls, 1);
        chk("rst_act",   a_act, 1);

        rst = 1'b0;
        #1;
        a_hs_p = a_hs; a_bl_p = a_bl; s_vs_p = s_vs; z_hs_p = z_hs;

        for (int k = 0; k <= MRST_K; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) chk("first_edge_x", a_x, 1);

            if (k < A_SPAN) begin
                if (a_ls) a_lsq.push_back(k);
                if (k > 0 && a_hs_p && !a_hs) a_hs_fall.push_back(k);
                if (k > 0 && !a_hs_p && a_hs) a_hs_rise.push_back(k);
                if (k > 0 && !a_bl_p && a_bl) a_bl_rise.push_back(k);
                if (k > 0 && a_bl_p && !a_bl) a_bl_fall.push_back(k);
                if (k < 800 && !a_hs) a_hs_low_l0++;
                if (k >= 800 && k < 1600 && a_bl) a_bl_high_l1++;
                if (int'(a_x) > a_xmax) a_xmax = int'(a_x);
                if (!a_act && (a_x != 0 || a_y != 0)) a_zero_viol++;
                if (k == 805) begin a_x805 = int'(a_x); a_y805 = int'(a_y); end
                if (k == 640) begin a_x640 = int'(a_x); a_act640 = int'(a_act); end
                a_hs_p = a_hs; a_bl_p = a_bl;

                if (z_bl !== z_act) z_bl_viol++;
                if (k > 0 && z_hs_p && !z_hs && z_hs_fall < 0) begin
                    z_hs_fall = k; z_x_at_fall = int'(z_x);
                end
                if (k > 0 && !z_hs_p && z_hs && z_hs_rise < 0) z_hs_rise = k;
                z_hs_p = z_hs;
            end

            if (k <= S_FRAME) begin
                if (s_fs) s_fsq.push_back(k);
                if (k < S_FRAME) begin
                    if (k > 0 && s_vs_p && !s_vs && s_vs_fall < 0) s_vs_fall = k;
                    if (!s_vs) s_vs_low++;
                    if (s_act) s_act_cnt++;
                    if (int'(s_x) > s_xmax) s_xmax = int'(s_x);
                    if (int'(s_y) > s_ymax) s_ymax = int'(s_y);
                    if (!s_act && (s_x != 0 || s_y != 0)) s_zero_viol++;
                end
                s_vs_p = s_vs;
            end
        end

        chk("line_period_0", qget(a_lsq, 1) - qget(a_lsq, 0), 800);
        chk("line_period_1", qget(a_lsq, 2) - qget(a_lsq, 1), 800);
        chk("hs_fall_l0",    qget(a_hs_fall, 0) - qget(a_lsq, 0), 658);
        chk("hs_width_l0",   qget(a_hs_rise, 0) - qget(a_hs_fall, 0), 96);
        chk("hs_fall_l1",    qget(a_hs_fall, 1) - qget(a_lsq, 1), 658);
        chk("hs_low_cnt",    a_hs_low_l0, 96);
        chk("blank_rise",    qget(a_bl_rise, 0), 2);
        chk("blank_fall",    qget(a_bl_fall, 0), 642);
        chk("blank_high_l1", a_bl_high_l1, 640);
        chk("x_max_line",    a_xmax, 639);
        chk("xy_zero_a",     a_zero_viol, 0);
        chk("x_at_805",      a_x805, 5);
        chk("y_at_805",      a_y805, 1);
        chk("x_at_640",      a_x640, 0);
        chk("act_at_640",    a_act640, 0);

        chk("frame_period",  qget(s_fsq, 1) - qget(s_fsq, 0), S_FRAME);
        chk("vs_fall",       s_vs_fall - qget(s_fsq, 0), 23*800 + 2);
        chk("vs_low_cnt",    s_vs_low, 1600);
        chk("s_x_max",       s_xmax, 639);
        chk("s_y_max",       s_ymax, 19);
        chk("s_act_cnt",     s_act_cnt, 20*640);
        chk("xy_zero_s",     s_zero_viol, 0);

        chk("z_blank_eq_act", z_bl_viol, 0);
        chk("z_hs_fall",      z_hs_fall, 656);
        chk("z_x_at_fall",    z_x_at_fall, 0);
        chk("z_hs_width",     z_hs_rise - z_hs_fall, 96);

        // dut_s is at line 10, h_cnt 700: inside the HS low window.
        chk("mrst_hs_pre", s_hs, 0);
        rst = 1'b1;
        #1;
        chk("mrst_hs_async", s_hs, 1);
        chk("mrst_vs",       s_vs, 1);
        chk("mrst_blank",    s_bl, 0);
        chk("mrst_fs",       s_fs, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_fs_release", s_fs, 1);
        m_hs_p = s_hs;
        for (int j = 1; j < 800; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("mrst_x_after", s_x, 1);
                chk("mrst_fs_after", s_fs, 0);
            end
            if (m_hs_p && !s_hs && m_hs_fall < 0) m_hs_fall = j;
            if (!s_hs) m_hs_low++;
            m_hs_p = s_hs;
        end
        chk("mrst_hs_fall", m_hs_fall, 658);
        chk("mrst_hs_low",  m_hs_low, 96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
